rx_frame_frontend: RTL and testbench

RX_FRAME_FRONTEND -- requirements
Module: rx_frame_frontend

---
 rtl/rx_frame_frontend.sv | 149 ++++++++++++++
 tb/tb_rx_frame_frontend.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_frontend.sv
// Receive frame front end: strips preamble/SFD and the trailing 4-byte FCS, reports per-frame status.
// Optional FCS checking is compiled in when RX_CRC_CHECK_EN is defined.
module rx_frame_frontend #(
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  data_out,
  output logic        en_out,
  output logic        frame_done,
  output logic        crc_err,
  output logic        runt,
  output logic        phy_err,
  output logic [11:0] frame_len
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [7:0]  PRE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE  = 8'hD5;
  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);

  state_t          state, state_nxt;
  logic [7:0]      rxd_r;
  logic            rx_dv_r, rx_er_r;
  logic [3:0][7:0] dly_line;
  logic [11:0]     cnt;
  logic            phy_acc;
  logic            start, shift, finish;

  // NOTE: every clocked process uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_r   <= '0;
      rx_dv_r <= 1'b0;
      rx_er_r <= 1'b0;
      state   <= IDLE;
    end else begin
      rxd_r   <= rxd;
      rx_dv_r <= rx_dv;
      rx_er_r <= rx_er;
      state   <= state_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE, PRE: begin
        if (!rx_dv_r) begin
          state_nxt = IDLE;
        end else if (rxd_r == PRE_BYTE) begin
          state_nxt = PRE;
        end else if (rxd_r == SFD_BYTE) begin
          state_nxt = DATA;
          start     = 1'b1;
        end else begin
          state_nxt = DROP;
        end
      end
      DATA: begin
        if (rx_dv_r) begin
          shift = 1'b1;
        end else begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      DROP: if (!rx_dv_r) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bytes leave the delay line only once four newer bytes have arrived, so the FCS never escapes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dly_line   <= '0;
      cnt        <= '0;
      phy_acc    <= 1'b0;
      data_out   <= '0;
      en_out     <= 1'b0;
      frame_done <= 1'b0;
      runt       <= 1'b0;
      phy_err    <= 1'b0;
      frame_len  <= '0;
    end else begin
      en_out     <= 1'b0;
      frame_done <= 1'b0;
      if (start) begin
        cnt     <= '0;
        phy_acc <= 1'b0;
      end
      if (shift) begin
        dly_line <= {dly_line[2:0], rxd_r};
        data_out <= dly_line[3];
        en_out   <= (cnt >= 12'd4);
        cnt      <= (cnt == 12'hFFF) ? cnt : cnt + 12'd1;
        phy_acc  <= phy_acc | rx_er_r;
      end
      if (finish) begin
        frame_done <= 1'b1;
        frame_len  <= cnt;
        runt       <= (cnt < MIN_LEN_W);
        phy_err    <= phy_acc;
      end
    end
  end

`ifdef RX_CRC_CHECK_EN
  // The good-frame residue is quoted MSB-first; the reflected register holds it bit-reversed.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  logic [31:0] crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc     <= '1;
      crc_err <= 1'b0;
    end else begin
      if (start) crc <= '1;
      if (shift) crc <= crc_step(crc, rxd_r);
      if (finish) crc_err <= (bit_rev(crc) != CRC_RESIDUE);
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_frontend.sv
// Directed bench for rx_frame_frontend: clean, corrupted, dropped, errored, reset-truncated,
// short, empty and oversize frames, with hand-derived expectations per frame.
module tb_rx_frame_frontend;

  typedef logic [7:0] byte_q_t [$];

  typedef struct {
    int   len;
    logic crc;
    logic runt;
    logic phy;
    int   n_en;
    int   first_en;
    int   last_en;
    int   done;
    int   start;
  } rec_t;

`ifdef RX_CRC_CHECK_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxd;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  data_out;
  logic        en_out;
  logic        frame_done;
  logic        crc_err;
  logic        runt;
  logic        phy_err;
  logic [11:0] frame_len;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pay_cyc = 0;
  int   n_en = 0;
  int   first_en = 0;
  int   last_en = 0;
  rec_t recs[$];
  logic [7:0] en_bytes[$];

  rx_frame_frontend #(.MIN_LEN(64)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .data_out(data_out), .en_out(en_out), .frame_done(frame_done),
    .crc_err(crc_err), .runt(runt), .phy_err(phy_err), .frame_len(frame_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) n_en = 0;
    if (en_out) begin
      if (n_en == 0) first_en = cyc;
      n_en++;
      last_en = cyc;
      en_bytes.push_back(data_out);
    end
    if (frame_done) begin
      recs.push_back('{int'(frame_len), crc_err, runt, phy_err, n_en, first_en, last_en, cyc,
                       en_bytes.size() - n_en});
      n_en = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fcs_of(input byte_q_t p);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (p[i]) begin
      c = c ^ {24'd0, p[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // 7 preamble bytes, SFD, payload byte k = k, FCS LSB first; optional byte flipped after FCS.
  function automatic byte_q_t build(input int n_pay, input int flip);
    byte_q_t q, p;
    logic [31:0] f;
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 0; i < n_pay; i++) p.push_back(8'(i));
    f = fcs_of(p);
    if (flip >= 0) p[flip] = p[flip] ^ 8'hFF;
    foreach (p[i]) q.push_back(p[i]);
    for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
    return q;
  endfunction

  task automatic send_range(input byte_q_t q, input int lo, input int hi, input int er_idx);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      rxd   = q[i];
      rx_dv = 1'b1;
      rx_er = (i == er_idx);
      if (i == 8) pay_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxd = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
    end
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 40 && recs.size() < n; i++) @(negedge clk);
    check("done_count", recs.size(), n);
  endtask

  task automatic check_rec(input string tag, input int len, input logic crc, input logic rn,
                           input logic phy, input int en_cnt);
    rec_t r;
    if (recs.size() == 0) begin
      check({tag, "_present"}, 0, 1);
      return;
    end
    r = recs[recs.size()-1];
    check({tag, "_len"}, r.len, len);
    check({tag, "_crc"}, 32'(r.crc), 32'(crc));
    check({tag, "_runt"}, 32'(r.runt), 32'(rn));
    check({tag, "_phy"}, 32'(r.phy), 32'(phy));
    check({tag, "_n_en"}, r.n_en, en_cnt);
    if (en_cnt > 0) begin
      check({tag, "_done_after_en"}, r.done, r.last_en + 1);
      check({tag, "_en_contig"}, r.last_en - r.first_en + 1, en_cnt);
    end
  endtask

  task automatic check_data(input string tag, input int flip);
    rec_t r;
    int bad;
    logic [7:0] exp;
    if (recs.size() == 0) return;
    r = recs[recs.size()-1];
    bad = 0;
    for (int k = 0; k < r.n_en; k++) begin
      exp = (k == flip) ? ~8'(k) : 8'(k);
      if (en_bytes[r.start + k] !== exp) bad++;
    end
    check({tag, "_data_bad_bytes"}, bad, 0);
  endtask

  initial begin
    byte_q_t q, qd;
    int n;

    rst = 1'b0; rxd = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en_out", 32'(en_out), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_len", 32'(frame_len), 0);
    check("rst_data_out", 32'(data_out), 0);
    rst = 1'b1;
    idle(2);

    // Clean minimum-size frame.
    q = build(60, -1);
    send_range(q, 0, q.size(), -1);
    idle(1);
    wait_done(1);
    check_rec("good", 64, 1'b0, 1'b0, 1'b0, 60);
    check_data("good", -1);
    check("good_latency", recs[0].first_en - pay_cyc, 6);
    check("good_held_len", 32'(frame_len), 64);

    // Corrupted payload byte 10.
    q = build(60, 10);
    send_range(q, 0, q.size(), -1);
    idle(1);
    wait_done(2);
    check_rec("bad_fcs", 64, CRC_ON, 1'b0, 1'b0, 60);
    check_data("bad_fcs", 10);

    // Broken preamble with SFD/preamble look-alikes, then a frame after a one-cycle gap.
    qd = {8'h55, 8'h55, 8'h12};
    for (int i = 0; i < 20; i++) qd.push_back(i[0] ? 8'hD5 : 8'h55);
    send_range(qd, 0, qd.size(), -1);
    idle(1);
    q = build(60, -1);
    send_range(q, 0, q.size(), -1);
    idle(1);
    wait_done(3);
    check_rec("after_drop", 64, 1'b0, 1'b0, 1'b0, 60);
    check_data("after_drop", -1);

    // 40-byte frame with rx_er on payload byte 15.
    q = build(36, -1);
    send_range(q, 0, q.size(), 8 + 15);
    idle(1);
    wait_done(4);
    check_rec("phy", 40, 1'b0, 1'b1, 1'b1, 36);
    check_data("phy", -1);

    // Reset for 3 cycles at payload byte 30 of a 64-byte frame.
    q = build(60, -1);
    send_range(q, 0, 38, -1);
    check("held_len_before_rst", 32'(frame_len), 40);
    check("en_before_rst", 32'(en_out), 1);
    @(negedge clk); rst = 1'b0; rxd = q[38];
    @(negedge clk);
    check("midrst_en_out", 32'(en_out), 0);
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_frame_done", 32'(frame_done), 0);
    check("midrst_runt", 32'(runt), 0);
    check("midrst_phy_err", 32'(phy_err), 0);
    check("midrst_crc_err", 32'(crc_err), 0);
    check("midrst_frame_len", 32'(frame_len), 0);
    rxd = q[39];
    @(negedge clk); rxd = q[40];
    @(negedge clk); rst = 1'b1; rxd = q[41];
    send_range(q, 42, q.size(), -1);
    idle(1);
    n = recs.size();
    repeat (20) @(negedge clk);
    check("rst_no_done", recs.size(), n);
    check("rst_no_en", 32'(en_out), 0);
    q = build(60, -1);
    send_range(q, 0, q.size(), -1);
    idle(1);
    wait_done(n + 1);
    check_rec("post_rst", 64, 1'b0, 1'b0, 1'b0, 60);
    check_data("post_rst", -1);

    // SFD plus 3 bytes.
    q = {8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hAA, 8'hBB, 8'hCC};
    send_range(q, 0, q.size(), -1);
    idle(1);
    wait_done(n + 2);
    check_rec("short3", 3, CRC_ON, 1'b1, 1'b0, 0);

    // SFD immediately followed by rx_dv low.
    q = {8'h55, 8'h55, 8'hD5};
    send_range(q, 0, q.size(), -1);
    idle(1);
    wait_done(n + 3);
    check_rec("empty", 0, CRC_ON, 1'b1, 1'b0, 0);

    // Oversize frame: length counter saturates.
    q = {8'h55, 8'hD5};
    for (int i = 0; i < 4100; i++) q.push_back(8'(i));
    send_range(q, 0, q.size(), -1);
    idle(1);
    wait_done(n + 4);
    check("long_len", recs[recs.size()-1].len, 4095);
    check("long_runt", 32'(recs[recs.size()-1].runt), 0);
    check("held_len_final", 32'(frame_len), 4095);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
